fsm_mod_counter: RTL and testbench

//   Parametrised modulo counter built around an explicit state machine.

---
 rtl/fsm_mod_counter.sv | 90 +++++++++
 tb/tb_fsm_mod_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_mod_counter.sv
// Modulo counter sequenced by an up/down/saturate FSM with run-time limit,
// registered binary + Gray outputs and a terminal-count pulse.
module fsm_mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             dir_o,
  output logic             tc,
  output logic             sat
);
  typedef enum logic [1:0] {S_UP, S_DOWN, S_SAT} state_t;

  localparam logic [1:0] M_UP = 2'd0, M_DOWN = 2'd1, M_PING = 2'd2, M_HOLD = 2'd3;

  state_t           state, state_nxt;
  logic [1:0]       sat_mode, sat_mode_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt, down, at_bnd, sat_hold;

  // S_SAT only stays put while the mode that caused it is still selected
  assign sat_hold = (state == S_SAT) && (mode == sat_mode);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    sat_mode_nxt = sat_mode;
    tc_nxt       = 1'b0;
    down         = 1'b0;
    at_bnd       = 1'b0;
    if (clear) begin
      state_nxt = S_UP;
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
      state_nxt = (mode == M_DOWN) ? S_DOWN : S_UP;
    end else if (en && mode != M_HOLD && !sat_hold) begin
      case (mode)
        M_UP:    down = 1'b0;
        M_DOWN:  down = 1'b1;
        // ping-pong leaving S_SAT resumes the direction it saturated in
        default: down = (state == S_SAT) ? (sat_mode == M_DOWN) : (state == S_DOWN);
      endcase
      at_bnd = down ? (count == '0) : (count >= limit);
      tc_nxt = at_bnd;
      if (!at_bnd) begin
        count_nxt = down ? count - WIDTH'(1) : count + WIDTH'(1);
        state_nxt = down ? S_DOWN : S_UP;
      end else if (mode != M_PING && saturate) begin
        state_nxt    = S_SAT;
        sat_mode_nxt = mode;
      end else if (mode == M_PING) begin
        count_nxt = (limit == '0) ? '0 : (down ? WIDTH'(1) : limit - WIDTH'(1));
        state_nxt = down ? S_UP : S_DOWN;
      end else begin
        count_nxt = down ? limit : '0;
        state_nxt = down ? S_DOWN : S_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_UP;
      sat_mode   <= M_UP;
      count      <= '0;
      count_gray <= '0;
      dir_o      <= 1'b0;
      tc         <= 1'b0;
      sat        <= 1'b0;
    end else begin
      state      <= state_nxt;
      sat_mode   <= sat_mode_nxt;
      count      <= count_nxt;
      count_gray <= count_nxt ^ (count_nxt >> 1);
      dir_o      <= (state_nxt == S_DOWN);
      tc         <= tc_nxt;
      sat        <= (state_nxt == S_SAT);
    end
  end
endmodule

// File: tb/tb_fsm_mod_counter.sv
// Bench for fsm_mod_counter: directed vector table, async reset/clear
// sequences, then randomized traffic against an arithmetic reference model.
module tb_fsm_mod_counter;
  logic       clk, reset, clear, en, load, saturate;
  logic [3:0] load_val, limit, count, count_gray;
  logic [1:0] mode;
  logic       dir_o, tc, sat;

  int checks = 0, failures = 0;

  fsm_mod_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .load(load),
    .load_val(load_val), .limit(limit), .mode(mode), .saturate(saturate),
    .count(count), .count_gray(count_gray), .dir_o(dir_o), .tc(tc), .sat(sat)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    bit clr, e, ld; int lv, lim, md; bit st;
    int xc; bit xtc, xdir, xsat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int v);
    return (v ^ (v >> 1)) & 15;
  endfunction

  // Reference model state: plain integers, direction as a flag
  int m_count, m_smode; bit m_down, m_sat, m_tc;

  task automatic model_reset();
    m_count = 0; m_down = 0; m_sat = 0; m_tc = 0; m_smode = 0;
  endtask

  task automatic model_step(input bit c, input bit e, input bit ld, input int lv,
                            input int lim, input int md, input bit st);
    bit d, bnd;
    if (c) begin
      m_count = 0; m_down = 0; m_sat = 0; m_tc = 0;
    end else if (ld) begin
      m_count = (lv < lim) ? lv : lim; m_down = (md == 1); m_sat = 0; m_tc = 0;
    end else if (!e || md == 3 || (m_sat && md == m_smode)) begin
      m_tc = 0;
    end else begin
      if (md == 0) d = 0;
      else if (md == 1) d = 1;
      else if (m_sat) d = (m_smode == 1);
      else d = m_down;
      m_sat = 0;
      bnd = d ? (m_count == 0) : (m_count >= lim);
      m_tc = bnd;
      if (!bnd) begin
        m_count = d ? m_count - 1 : m_count + 1; m_down = d;
      end else if (md != 2 && st) begin
        m_sat = 1; m_smode = md;
      end else if (md == 2) begin
        m_count = (lim == 0) ? 0 : (d ? 1 : lim - 1); m_down = !d;
      end else begin
        m_count = d ? lim : 0; m_down = d;
      end
    end
  endtask

  task automatic drive(input bit c, input bit e, input bit ld, input int lv,
                       input int lim, input int md, input bit st);
    clear = c; en = e; load = ld; load_val = 4'(lv); limit = 4'(lim);
    mode = 2'(md); saturate = st;
  endtask

  vec_t vt[$];

  task automatic addv(input bit c, input bit e, input bit ld, input int lv, input int lim,
                      input int md, input bit st, input int xc, input bit xtc,
                      input bit xdir, input bit xsat);
    vec_t v;
    v.clr = c; v.e = e; v.ld = ld; v.lv = lv; v.lim = lim; v.md = md; v.st = st;
    v.xc = xc; v.xtc = xtc; v.xdir = xdir; v.xsat = xsat;
    vt.push_back(v);
  endtask

  initial begin
    reset = 1; drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_count", count, 0); chk("reset_gray", count_gray, 0);
    chk("reset_tc", tc, 0); chk("reset_dir", dir_o, 0); chk("reset_sat", sat, 0);
    @(negedge clk); reset = 0;

    // up wrap, limit 5
    for (int i = 1; i <= 5; i++) addv(0, 1, 0, 0, 5, 0, 0, i, 0, 0, 0);
    addv(0, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0);
    addv(0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
    // ping-pong, limit 3
    addv(1, 1, 0, 0, 3, 2, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 2, 0, 0, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 3, 0, 0, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 2, 1, 1, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 1, 0, 1, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 3, 2, 0, 1, 1, 0, 0);
    // down with saturation
    addv(0, 0, 1, 2, 5, 1, 1, 2, 0, 1, 0);
    addv(0, 1, 0, 0, 5, 1, 1, 1, 0, 1, 0);
    addv(0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 5, 1, 1, 0, 1, 0, 1);
    addv(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1);
    // load clamps and beats en; then wrap from limit
    addv(0, 1, 1, 12, 9, 0, 0, 9, 0, 0, 0);
    addv(0, 1, 0, 0, 9, 0, 0, 0, 1, 0, 0);
    // hold mode
    addv(0, 1, 0, 0, 9, 3, 0, 0, 0, 0, 0);
    // limit lowered below count: down steps normally, up wraps
    addv(0, 0, 1, 8, 15, 0, 0, 8, 0, 0, 0);
    addv(0, 1, 0, 0, 4, 1, 0, 7, 0, 1, 0);
    addv(0, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    // limit 0 keeps count at 0
    addv(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    addv(0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0);

    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].e, vt[i].ld, vt[i].lv, vt[i].lim, vt[i].md, vt[i].st);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), count, vt[i].xc);
      chk($sformatf("vec%0d_gray", i), count_gray, gray(vt[i].xc));
      chk($sformatf("vec%0d_tc", i), tc, vt[i].xtc);
      chk($sformatf("vec%0d_dir", i), dir_o, vt[i].xdir);
      chk($sformatf("vec%0d_sat", i), sat, vt[i].xsat);
    end

    // Gray transitions 7->8 and 15->0
    drive(0, 0, 1, 7, 15, 0, 0); @(posedge clk); #1;
    chk("gray7", count_gray, 4'b0100);
    drive(0, 1, 0, 0, 15, 0, 0); @(posedge clk); #1;
    chk("gray8", count_gray, 4'b1100);
    drive(0, 0, 1, 15, 15, 0, 0); @(posedge clk); #1;
    chk("gray15", count_gray, 4'b1000);
    drive(0, 1, 0, 0, 15, 0, 0); @(posedge clk); #1;
    chk("wrap_gray", count_gray, 0); chk("wrap_tc", tc, 1);

    // async reset between edges, at count 6
    drive(1, 0, 0, 0, 9, 0, 0); @(posedge clk); #1;
    drive(0, 1, 0, 0, 9, 0, 0);
    repeat (6) @(posedge clk);
    #1; chk("pre_reset_count", count, 6);
    #2 reset = 1; #1;
    chk("async_count", count, 0); chk("async_gray", count_gray, 0); chk("async_tc", tc, 0);
    #1 reset = 0;
    repeat (4) @(posedge clk);
    #1; chk("pre_clear_count", count, 4);
    drive(1, 1, 0, 0, 9, 0, 0); @(posedge clk); #1;
    chk("clear_count", count, 0);

    // randomized run against the model
    drive(1, 0, 0, 0, 9, 0, 0); @(posedge clk); #1;
    model_reset();
    begin
      int lim = 9, md = 0; bit st = 0;
      for (int n = 0; n < 3000; n++) begin
        bit c, e, ld; int lv;
        if ($urandom_range(99) < 3) lim = $urandom_range(15);
        if ($urandom_range(99) < 8) md = $urandom_range(3);
        if ($urandom_range(99) < 5) st = $urandom_range(1);
        c  = ($urandom_range(99) < 2);
        ld = ($urandom_range(99) < 5);
        e  = ($urandom_range(99) < 85);
        lv = $urandom_range(15);
        drive(c, e, ld, lv, lim, md, st);
        model_step(c, e, ld, lv, lim, md, st);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_count", n), count, m_count);
        chk($sformatf("rnd%0d_gray", n), count_gray, gray(m_count));
        chk($sformatf("rnd%0d_tc", n), tc, m_tc);
        chk($sformatf("rnd%0d_dir", n), dir_o, (!m_sat && m_down));
        chk($sformatf("rnd%0d_sat", n), sat, m_sat);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
